// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave that snapshots a fabric word for software, with a fresh flag,
// a saturating overrun count, a free-running capture count and a freeze control.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h0108F400,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108F4FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam bit unused_family = (C_FAMILY == "virtex5");

    // Buses re-viewed with bit 0 as LSB so offsets and flags read naturally.
    logic [C_OPB_AWIDTH-1:0] abus_s;
    logic [C_OPB_DWIDTH-1:0] wdbus_s;
    assign abus_s  = OPB_ABus;
    assign wdbus_s = OPB_DBus;

    state_t      state_q;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;
    logic [5:0]  off_q;
    logic        rnw_q;
    logic        be3_q;
    logic [1:0]  wd_q;
    logic [31:0] data_q, data_d;
    logic        fresh_q, fresh_d;
    logic        freeze_q, freeze_d;
    logic [15:0] ovr_q, ovr_d;
    logic [31:0] cap_q, cap_d;

    logic hit_s, go_ack_s, in_ack_s, ctl_wr_s, data_rd_s, cap_s;

    assign hit_s     = OPB_select && (abus_s >= C_BASEADDR) && (abus_s <= C_HIGHADDR);
    assign go_ack_s  = (state_q == IDLE) && hit_s;
    assign in_ack_s  = (state_q == ACK);
    assign ctl_wr_s  = in_ack_s && !rnw_q && (off_q == 6'd2) && be3_q;
    assign data_rd_s = in_ack_s && rnw_q && (off_q == 6'd0);
    assign cap_s     = user_data_valid && !freeze_q;

    // Next-state of the snapshot registers, flags and counters.
    always_comb begin
        data_d   = cap_s ? user_data_in : data_q;
        cap_d    = cap_q + {31'd0, cap_s};
        freeze_d = ctl_wr_s ? wd_q[0] : freeze_q;
        if (cap_s) begin
            fresh_d = 1'b1;
        end else if (data_rd_s) begin
            fresh_d = 1'b0;
        end else begin
            fresh_d = fresh_q;
        end
        if (ctl_wr_s && wd_q[1]) begin
            ovr_d = 16'd0;
        end else if (cap_s && fresh_q && !data_rd_s && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Read data is prepared from next-state values so a capture just before the ACK is seen.
    always_comb begin
        rdata_d = 32'd0;
        if (go_ack_s && OPB_RNW) begin
            case (abus_s[7:2])
                6'd0:    rdata_d = data_d;
                6'd1:    rdata_d = {ovr_d, 14'd0, freeze_d, fresh_d};
                6'd2:    rdata_d = {31'd0, freeze_d};
                6'd3:    rdata_d = cap_d;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Slave FSM, registered bus outputs and user-side state.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            rdata_q  <= 32'd0;
            off_q    <= 6'd0;
            rnw_q    <= 1'b0;
            be3_q    <= 1'b0;
            wd_q     <= 2'd0;
            data_q   <= 32'd0;
            fresh_q  <= 1'b0;
            freeze_q <= 1'b0;
            ovr_q    <= 16'd0;
            cap_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_ack_s) begin
                        state_q <= ACK;
                        off_q   <= abus_s[7:2];
                        rnw_q   <= OPB_RNW;
                        be3_q   <= OPB_BE[3];
                        wd_q    <= wdbus_s[1:0];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            ack_q    <= go_ack_s;
            rdata_q  <= rdata_d;
            data_q   <= data_d;
            fresh_q  <= fresh_d;
            freeze_q <= freeze_d;
            ovr_q    <= ovr_d;
            cap_q    <= cap_d;
        end
    end

    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, OPB_seqAddr, OPB_BE[0:2], wdbus_s[C_OPB_DWIDTH-1:2],
                             abus_s[1:0], unused_family};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench for the simulink2ppc snapshot register with a transaction-level model.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h0108F400;
    localparam logic [31:0] HIGH = 32'h0108F4FF;
    localparam logic [31:0] A_DATA = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_CTRL = BASE + 32'h08;
    localparam logic [31:0] A_CAPC = BASE + 32'h0C;

    logic        clk = 1'b0;
    logic        OPB_Rst = 1'b1;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
    logic [0:31] OPB_ABus = 32'd0;
    logic [0:3]  OPB_BE = 4'd0;
    logic [0:31] OPB_DBus = 32'd0;
    logic        OPB_RNW = 1'b0;
    logic        OPB_select = 1'b0;
    logic        OPB_seqAddr = 1'b0;
    logic [31:0] user_data_in = 32'd0;
    logic        user_data_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk(clk), .OPB_Rst(OPB_Rst), .Sl_DBus(Sl_DBus), .Sl_errAck(Sl_errAck),
        .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup), .Sl_xferAck(Sl_xferAck),
        .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE), .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW),
        .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
        .user_data_in(user_data_in), .user_data_valid(user_data_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what software should observe, driven by the rules of the register map.
    logic [31:0] m_data = 32'd0, m_cap = 32'd0;
    logic [15:0] m_ovr = 16'd0;
    bit          m_fresh = 1'b0, m_freeze = 1'b0;
    bit          exp_ack = 1'b0;
    logic [31:0] exp_dbus = 32'd0;
    bit          t_rnw = 1'b0;
    logic [5:0]  t_off = 6'd0;
    logic [0:3]  t_be = 4'd0;
    logic [31:0] t_wd = 32'd0;

    function automatic logic [31:0] model_read(input logic [5:0] off);
        case (off)
            6'd0:    return m_data;
            6'd1:    return {m_ovr, 14'd0, m_freeze, m_fresh};
            6'd2:    return {31'd0, m_freeze};
            6'd3:    return m_cap;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit in_ack, dread, clr, acc, nfz;
        logic [31:0] a;
        if (OPB_Rst) begin
            m_data = 32'd0; m_cap = 32'd0; m_ovr = 16'd0; m_fresh = 1'b0; m_freeze = 1'b0;
            exp_ack = 1'b0; exp_dbus = 32'd0;
        end else begin
            in_ack = exp_ack;
            dread  = in_ack && t_rnw && (t_off == 6'd0);
            nfz    = m_freeze;
            clr    = 1'b0;
            if (in_ack && !t_rnw && (t_off == 6'd2) && t_be[3]) begin
                nfz = t_wd[0];
                clr = t_wd[1];
            end
            acc = user_data_valid && !m_freeze;
            if (acc) begin
                if (m_fresh && !dread && (m_ovr != 16'hFFFF)) m_ovr = m_ovr + 16'd1;
                m_data  = user_data_in;
                m_cap   = m_cap + 32'd1;
                m_fresh = 1'b1;
            end else if (dread) begin
                m_fresh = 1'b0;
            end
            if (clr) m_ovr = 16'd0;
            m_freeze = nfz;
            a = OPB_ABus;
            exp_ack = !in_ack && OPB_select && (a >= BASE) && (a <= HIGH);
            if (exp_ack) begin
                t_rnw = OPB_RNW; t_off = a[7:2]; t_be = OPB_BE; t_wd = OPB_DBus;
            end
            exp_dbus = (exp_ack && OPB_RNW) ? model_read(a[7:2]) : 32'd0;
        end
    end

    // Every cycle: handshake, read bus and tied-off outputs against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_ack", {31'd0, Sl_xferAck}, {31'd0, exp_ack});
            chk("cyc_dbus", Sl_DBus, exp_dbus);
            chk("cyc_tied", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
        end
    end

    task automatic xfer(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit cap_in_ack, input logic [31:0] cdata,
                        output logic [31:0] rdata, output bit acked);
        @(negedge clk);
        OPB_select = 1'b1; OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wdata; OPB_BE = be;
        @(negedge clk);
        acked = Sl_xferAck;
        rdata = Sl_DBus;
        OPB_select = 1'b0; OPB_ABus = 32'd0; OPB_DBus = 32'd0; OPB_BE = 4'd0;
        if (cap_in_ack) begin
            user_data_valid = 1'b1; user_data_in = cdata;
        end
        @(negedge clk);
        user_data_valid = 1'b0;
        // A silent slave is allowed a short bounded wait before the miss is recorded.
        if (!acked) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (Sl_xferAck) acked = 1'b1;
            end
        end
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r; bit ak;
        xfer(1'b1, addr, 32'd0, 4'hF, 1'b0, 32'd0, r, ak);
        chk({name, "_ack"}, {31'd0, ak}, 32'd1);
        chk(name, r, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r; bit ak;
        xfer(1'b0, addr, d, be, 1'b0, 32'd0, r, ak);
        chk("wr_ack", {31'd0, ak}, 32'd1);
    endtask

    task automatic pulse(input logic [31:0] d);
        @(negedge clk);
        user_data_valid = 1'b1; user_data_in = d;
        @(negedge clk);
        user_data_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r; bit ak;
        repeat (3) @(posedge clk);
        @(negedge clk);
        OPB_Rst = 1'b0;
        run_cmp = 1'b1;

        rd("reset_status", A_STAT, 32'h00000000);
        pulse(32'hDEADBEEF);
        rd("data1", A_DATA, 32'hDEADBEEF);
        rd("status_cleared", A_STAT, 32'h00000000);
        rd("capcount1", A_CAPC, 32'd1);

        pulse(32'h11); pulse(32'h22); pulse(32'h33);
        rd("status_ovr2", A_STAT, 32'h00020001);
        wr(A_CTRL, 32'h00000002, 4'hF);
        rd("status_ovr_clr", A_STAT, 32'h00000001);
        rd("ctrl_selfclr", A_CTRL, 32'h00000000);

        wr(A_CTRL, 32'h00000001, 4'hF);
        rd("capcount4", A_CAPC, 32'd4);
        pulse(32'h12345678);
        rd("data_frozen", A_DATA, 32'h00000033);
        rd("capcount_frozen", A_CAPC, 32'd4);
        rd("status_freeze", A_STAT, 32'h00000002);
        wr(A_CTRL, 32'h00000000, 4'hF);

        pulse(32'h0BADF00D);
        xfer(1'b1, A_DATA, 32'd0, 4'hF, 1'b1, 32'hA5A5A5A5, r, ak);
        chk("coinc_read", r, 32'h0BADF00D);
        rd("coinc_status", A_STAT, 32'h00000001);
        rd("coinc_data", A_DATA, 32'hA5A5A5A5);
        rd("capcount6", A_CAPC, 32'd6);

        xfer(1'b0, A_CTRL, 32'h00000001, 4'hF, 1'b1, 32'hCAFEF00D, r, ak);
        rd("freeze_cap_data", A_DATA, 32'hCAFEF00D);
        pulse(32'h00000099);
        rd("capcount7", A_CAPC, 32'd7);
        wr(A_CTRL, 32'h00000000, 4'hF);
        pulse(32'h00000044);
        xfer(1'b0, A_CTRL, 32'h00000002, 4'hF, 1'b1, 32'h00000055, r, ak);
        rd("clr_wins", A_STAT, 32'h00000001);
        wr(A_CTRL, 32'h00000001, 4'hE);
        rd("be3_ignored", A_CTRL, 32'h00000000);

        rd("unmapped", BASE + 32'h20, 32'h00000000);
        xfer(1'b1, 32'h0108F500, 32'd0, 4'hF, 1'b0, 32'd0, r, ak);
        chk("outside_ack", {31'd0, ak}, 32'd0);
        chk("outside_dbus", r, 32'd0);

        pulse(32'h77);
        @(negedge clk);
        OPB_select = 1'b1; OPB_ABus = A_STAT; OPB_RNW = 1'b1; OPB_Rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_ack", {31'd0, Sl_xferAck}, 32'd0);
        OPB_select = 1'b0; OPB_Rst = 1'b0;
        rd("rst_data", A_DATA, 32'd0);
        rd("rst_status", A_STAT, 32'd0);
        rd("rst_ctrl", A_CTRL, 32'd0);
        rd("rst_capc", A_CAPC, 32'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
